// File: rtl/bus_uart_tx_if.sv
// Peripheral-bus signals between the MCU bus front-end and the UART transmitter.
// The front-end drives address/data/strobe; the block returns registered read data and a select flag.
interface bus_uart_tx_if;
  logic        we;
  logic [13:0] addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        rd_sel;

  modport master (output we, addr, wr_data, input rd_data, rd_sel);
  modport slave  (input we, addr, wr_data, output rd_data, rd_sel);
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a 2^FIFO_DEPTH_LOG2-entry byte FIFO.
// Optional build macro UART_TX_PARITY_EN adds a parity bit (CTRL[3]: 0 even, 1 odd).
module bus_uart_tx #(
  parameter int          CLK_FREQ        = 96000000,
  parameter int          BAUD            = 115200,
  parameter logic [13:0] BASE_ADDR       = 14'h0040,
  parameter int          FIFO_DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst,
  bus_uart_tx_if.slave  bus,
  output logic          tx,
  output logic          irq
);

  localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h1;
  localparam logic [3:0] OFF_CTRL   = 4'h2;
  localparam logic [3:0] OFF_LEVEL  = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- decode
  logic       w_hit;
  logic [3:0] w_off;
  logic       w_wr;
  logic       w_push_req;
  logic       w_flush;
  logic       w_ovf_clr;
  logic       w_ctrl_wr;

  assign w_hit      = (bus.addr[13:4] == BASE_ADDR[13:4]);
  assign w_off      = bus.addr[3:0];
  assign w_wr       = bus.we & w_hit;
  assign w_push_req = w_wr & (w_off == OFF_TXDATA);
  assign w_ctrl_wr  = w_wr & (w_off == OFF_CTRL);
  assign w_flush    = w_ctrl_wr & bus.wr_data[1];
  assign w_ovf_clr  = w_wr & (w_off == OFF_STATUS) & bus.wr_data[3];

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_push_drop;
  logic          w_pop;
  logic [7:0]    w_head;

  assign w_level     = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_level == PW'(DEPTH));
  assign w_empty     = (w_level == '0);
  assign w_push      = w_push_req & ~w_full & ~w_flush;
  assign w_push_drop = w_push_req & w_full & ~w_flush;
  assign w_head      = r_mem[r_rd_ptr[FIFO_DEPTH_LOG2-1:0]];

  // NOTE: the storage array has no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= bus.wr_data;
  end

  // Flush snaps the read pointer to the write pointer; any same-cycle pop is suppressed upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // ---------------------------------------------------------------- control / status
  logic r_tx_en;
  logic r_irq_en;
  logic r_overflow;
  logic r_par_odd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_en    <= 1'b1;
      r_irq_en   <= 1'b0;
      r_overflow <= 1'b0;
      r_par_odd  <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_tx_en  <= bus.wr_data[0];
        r_irq_en <= bus.wr_data[2];
`ifdef UART_TX_PARITY_EN
        r_par_odd <= bus.wr_data[3];
`endif
      end
      if (w_push_drop)    r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- transmit FSM
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_tx;
  logic             w_tx_nxt;
  logic             r_par_bit;
  logic             w_par_nxt;
  logic             w_avail;
  logic             w_busy;

  assign w_avail = r_tx_en & ~w_empty & ~w_flush;
  assign w_busy  = (r_state != S_IDLE);

  // NOTE: state registers take non-blocking assignments only; the combinational block below uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_par_bit <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_par_bit <= w_par_nxt;
    end
  end

  // tx is registered from w_tx_nxt so the line changes exactly on the state boundary.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - CNT_ONE;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_par_nxt   = r_par_bit;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_avail) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_par_nxt   = (^w_head) ^ r_par_odd;
          w_cnt_nxt   = CNT_LOAD;
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_LOAD;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_LOAD;
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx_nxt    = r_par_bit;
            w_state_nxt = S_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt  = r_shift[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_LOAD;
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (r_cnt == '0) begin
          // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
          if (w_avail) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_par_nxt   = (^w_head) ^ r_par_odd;
            w_cnt_nxt   = CNT_LOAD;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign tx  = r_tx;
  assign irq = w_empty & ~w_busy & r_irq_en;

  // ---------------------------------------------------------------- read path
  logic [7:0] w_rd_val;
  logic [7:0] r_rd_data;
  logic       r_rd_sel;

  always_comb begin
    w_rd_val = 8'h00;
    case (w_off)
      OFF_STATUS: w_rd_val = {4'b0000, r_overflow, w_empty, w_full, w_busy};
      OFF_CTRL:   w_rd_val = {4'b0000, r_par_odd, r_irq_en, 1'b0, r_tx_en};
      OFF_LEVEL:  w_rd_val = 8'(w_level);
      default:    w_rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= 8'h00;
      r_rd_sel  <= 1'b0;
    end else begin
      r_rd_data <= w_hit ? w_rd_val : 8'h00;
      r_rd_sel  <= w_hit;
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.rd_sel  = r_rd_sel;

  logic w_unused_bits;
  assign w_unused_bits = ^bus.wr_data[7:4];

endmodule
